cpu_run_controller: RTL and testbench

//  Sequences one program run of the 8-bit CPU core. Accepts a program byte stream

---
 rtl/cpu_run_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_cpu_run_controller.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// cpu_run_controller
// Sequences one program run of the 8-bit CPU core:
//   IDLE -> LOAD -> RUN -> DONE -> IDLE
// A host streams program bytes in over valid/ready. They are written to the
// 32x8 program/data memory through a one-cycle registered write path. The
// core is then released from reset with start_execution high for a bounded
// number of cycles. The controller owns the single memory port: the loader
// drives it in IDLE/LOAD, and the core drives it in RUN.
//
// Host handshake: a byte transfers on a rising clock edge where host_valid
// and host_ready are both high ("accept"). host_ready is a registered output
// and depends only on controller state, never on host_valid. The host may
// hold host_valid high for as long as it likes. host_valid is ignored
// whenever host_ready is low, which includes every state other than
// IDLE/LOAD.

module cpu_run_controller #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int CYC_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  // host program stream
  input  logic                  host_valid,
  input  logic [DATA_WIDTH-1:0] host_data,
  input  logic                  host_last,
  output logic                  host_ready,
  input  logic [CYC_WIDTH-1:0]  run_cycles,
  input  logic                  abort,
  input  logic                  done_ack,
  // core memory request
  input  logic [ADDR_WIDTH-1:0] core_mem_addr,
  input  logic [DATA_WIDTH-1:0] core_mem_wdata,
  input  logic                  core_mem_write,
  // core control
  output logic                  core_reset,
  output logic                  core_start,
  // memory port
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write,
  // status
  output logic                  busy,
  output logic                  done,
  output logic                  load_trunc,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic [CYC_WIDTH-1:0]  cycles_used,
  // debug view of the sequencer state (0 IDLE, 1 LOAD, 2 RUN, 3 DONE)
  output logic [1:0]            state_dbg
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = '0;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = '1;
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = '0;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_MAX   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [CYC_WIDTH-1:0]  CYC_ZERO  = '0;
  localparam logic [CYC_WIDTH-1:0]  CYC_ONE   = {{(CYC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] load_ptr;
  logic [CYC_WIDTH-1:0]  budget;

  // Pending loader write, presented on the memory port in the cycle after
  // the accept.
  logic                  ld_write;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;

  logic accept;
  logic final_beat;
  logic run_end;

  // A beat is final when it carries host_last, or when it fills the last
  // memory slot. In the second case the program is reported as truncated.
  always_comb begin
    accept     = host_valid & host_ready;
    final_beat = host_last | (load_ptr == PTR_LAST);
    run_end    = ((cycles_used + CYC_ONE) == budget) | abort;
  end

  assign state_dbg = state;

  // Sequencer: state, core control, handshake, counters and status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      host_ready  <= 1'b0;
      core_reset  <= 1'b1;
      core_start  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      load_trunc  <= 1'b0;
      load_count  <= CNT_ZERO;
      load_ptr    <= PTR_ZERO;
      budget      <= CYC_ZERO;
      cycles_used <= CYC_ZERO;
    end else begin
      case (state)
        ST_IDLE, ST_LOAD: begin
          // The core is held in reset and the host may stream bytes.
          host_ready <= 1'b1;
          core_reset <= 1'b1;
          core_start <= 1'b0;
          if (accept) begin
            if (load_ptr != PTR_LAST) begin
              load_ptr <= load_ptr + PTR_ONE;
            end
            if (load_count != CNT_MAX) begin
              load_count <= load_count + CNT_ONE;
            end
            if (final_beat) begin
              host_ready  <= 1'b0;
              load_trunc  <= ~host_last;
              budget      <= run_cycles;
              cycles_used <= CYC_ZERO;
              core_reset  <= 1'b0;
              if (run_cycles == CYC_ZERO) begin
                // An empty budget skips RUN. The core never sees start.
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state      <= ST_RUN;
                core_start <= 1'b1;
                busy       <= 1'b1;
              end
            end else begin
              state <= ST_LOAD;
              busy  <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          // Every RUN cycle counts, including the one that ends the run.
          cycles_used <= cycles_used + CYC_ONE;
          if (run_end) begin
            state      <= ST_DONE;
            core_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end

        ST_DONE: begin
          // The core stays out of reset so the host can inspect its state.
          // cycles_used holds its final value.
          if (done_ack) begin
            state      <= ST_IDLE;
            core_reset <= 1'b1;
            done       <= 1'b0;
            host_ready <= 1'b1;
            load_ptr   <= PTR_ZERO;
            load_count <= CNT_ZERO;
            load_trunc <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Loader write path. Each accept registers one memory write, which appears
  // on the port for exactly one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ld_write <= 1'b0;
      ld_addr  <= PTR_ZERO;
      ld_data  <= DATA_ZERO;
    end else begin
      ld_write <= accept;
      if (accept) begin
        ld_addr <= load_ptr;
        ld_data <= host_data;
      end
    end
  end

  // Memory port owner select. The final byte's pending write lands in the
  // first cycle after LOAD. It wins over the core in that cycle, so the
  // core can only read then. If the budget was zero, that first cycle is in
  // DONE instead of RUN, and the last byte is still written.
  always_comb begin
    mem_addr       = ld_addr;
    mem_write_data = ld_data;
    mem_write      = ld_write;
    case (state)
      ST_RUN: begin
        if (!ld_write) begin
          mem_addr       = core_mem_addr;
          mem_write_data = core_mem_wdata;
          mem_write      = core_mem_write;
        end
      end
      ST_DONE: begin
        if (!ld_write) begin
          mem_addr       = core_mem_addr;
          mem_write_data = core_mem_wdata;
          mem_write      = 1'b0;
        end
      end
      default: begin
        mem_addr       = ld_addr;
        mem_write_data = ld_data;
        mem_write      = ld_write;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed testbench for cpu_run_controller.
// A scoreboard watches every memory write on the falling edge and matches it
// against an expected queue of {addr, data} entries.

module tb_cpu_run_controller;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // clock / reset
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic        host_valid, host_last, host_ready;
  logic [7:0]  host_data;
  logic [15:0] run_cycles;
  logic        abort, done_ack;
  logic [4:0]  core_mem_addr;
  logic [7:0]  core_mem_wdata;
  logic        core_mem_write;
  logic        core_reset, core_start;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_write_data;
  logic        mem_write;
  logic        busy, done, load_trunc;
  logic [5:0]  load_count;
  logic [15:0] cycles_used;
  logic [1:0]  state_dbg;

  cpu_run_controller dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .host_valid     (host_valid),
    .host_data      (host_data),
    .host_last      (host_last),
    .host_ready     (host_ready),
    .run_cycles     (run_cycles),
    .abort          (abort),
    .done_ack       (done_ack),
    .core_mem_addr  (core_mem_addr),
    .core_mem_wdata (core_mem_wdata),
    .core_mem_write (core_mem_write),
    .core_reset     (core_reset),
    .core_start     (core_start),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .busy           (busy),
    .done           (done),
    .load_trunc     (load_trunc),
    .load_count     (load_count),
    .cycles_used    (cycles_used),
    .state_dbg      (state_dbg)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [12:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: every task starts and ends 1 time unit after a rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    host_valid = 1'b1;
    host_data  = d;
    host_last  = last;
    tick();
    host_valid = 1'b0;
    host_last  = 1'b0;
  endtask

  task automatic push(input logic [4:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!done && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic ack();
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
  endtask

  // scoreboard: every memory write must match the head of the queue
  always @(negedge clock) begin
    if (mem_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'({mem_addr, mem_write_data}), 32'h1_0000);
      end else begin
        check("mem_wr", 32'({mem_addr, mem_write_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [7:0] d;

    reset_n        = 1'b0;
    host_valid     = 1'b0;
    host_data      = 8'h00;
    host_last      = 1'b0;
    run_cycles     = 16'd0;
    abort          = 1'b0;
    done_ack       = 1'b0;
    core_mem_addr  = 5'd0;
    core_mem_wdata = 8'h00;
    core_mem_write = 1'b0;
    repeat (2) tick();

    // reset state
    check("rst_host_ready",  32'(host_ready), 32'd0);
    check("rst_core_reset",  32'(core_reset), 32'd1);
    check("rst_core_start",  32'(core_start), 32'd0);
    check("rst_mem_write",   32'(mem_write), 32'd0);
    check("rst_mem_addr",    32'(mem_addr), 32'd0);
    check("rst_mem_wdata",   32'(mem_write_data), 32'd0);
    check("rst_busy",        32'(busy), 32'd0);
    check("rst_done",        32'(done), 32'd0);
    check("rst_load_trunc",  32'(load_trunc), 32'd0);
    check("rst_load_count",  32'(load_count), 32'd0);
    check("rst_cycles_used", 32'(cycles_used), 32'd0);
    check("rst_state",       32'(state_dbg), 32'(S_IDLE));

    reset_n = 1'b1;
    tick();
    check("idle_host_ready", 32'(host_ready), 32'd1);
    check("idle_core_reset", 32'(core_reset), 32'd1);

    // T1: three-byte program, budget 8
    run_cycles = 16'd8;
    push(5'd0, 8'h20);
    push(5'd1, 8'h28);
    push(5'd2, 8'hE2);
    send(8'h20, 1'b0);
    check("t1_busy_load",   32'(busy), 32'd1);
    check("t1_state_load",  32'(state_dbg), 32'(S_LOAD));
    check("t1_wr_next_cyc", 32'(mem_write), 32'd1);
    check("t1_wr_addr0",    32'(mem_addr), 32'd0);
    send(8'h28, 1'b0);
    check("t1_pre_core_reset", 32'(core_reset), 32'd1);
    check("t1_pre_core_start", 32'(core_start), 32'd0);
    send(8'hE2, 1'b1);
    check("t1_run_core_start", 32'(core_start), 32'd1);
    check("t1_run_core_reset", 32'(core_reset), 32'd0);
    check("t1_load_count",     32'(load_count), 32'd3);
    check("t1_run_host_ready", 32'(host_ready), 32'd0);
    check("t1_state_run",      32'(state_dbg), 32'(S_RUN));
    cnt = 0;
    while (core_start && cnt < 1000) begin
      cnt++;
      tick();
    end
    check("t1_run_len",        32'(cnt), 32'd8);
    check("t1_done",           32'(done), 32'd1);
    check("t1_cycles_used",    32'(cycles_used), 32'd8);
    check("t1_done_core_rst",  32'(core_reset), 32'd0);
    check("t1_done_busy",      32'(busy), 32'd0);
    check("t1_state_done",     32'(state_dbg), 32'(S_DONE));
    core_mem_addr  = 5'd7;
    core_mem_wdata = 8'h55;
    core_mem_write = 1'b1;
    #1;
    check("t1_done_no_write",  32'(mem_write), 32'd0);
    check("t1_done_addr_pass", 32'(mem_addr), 32'd7);
    core_mem_write = 1'b0;
    core_mem_addr  = 5'd0;
    ack();
    check("t1_ack_host_ready", 32'(host_ready), 32'd1);
    check("t1_ack_done",       32'(done), 32'd0);
    check("t1_ack_core_reset", 32'(core_reset), 32'd1);
    check("t1_ack_load_count", 32'(load_count), 32'd0);
    check("t1_ack_state",      32'(state_dbg), 32'(S_IDLE));

    // T2: budget 12, loader priority in first RUN cycle, core pass-through
    run_cycles = 16'd12;
    push(5'd0, 8'hA1);
    push(5'd1, 8'hB2);
    send(8'hA1, 1'b0);
    send(8'hB2, 1'b1);
    cnt = 0;
    while (core_start && cnt < 1000) begin
      cnt++;
      core_mem_write = (cnt == 1) || (cnt == 3);
      core_mem_addr  = (cnt == 1) ? 5'd9 : 5'd5;
      core_mem_wdata = (cnt == 1) ? 8'h99 : 8'h3C;
      if (cnt == 3) push(5'd5, 8'h3C);
      #1;
      if (cnt == 1) check("t2_loader_prio", 32'(mem_addr), 32'd1);
      if (cnt == 3) begin
        check("t2_pass_addr",  32'(mem_addr), 32'd5);
        check("t2_pass_wdata", 32'(mem_write_data), 32'h3C);
        check("t2_pass_write", 32'(mem_write), 32'd1);
      end
      tick();
    end
    core_mem_write = 1'b0;
    check("t2_run_len",     32'(cnt), 32'd12);
    check("t2_done",        32'(done), 32'd1);
    check("t2_cycles_used", 32'(cycles_used), 32'd12);
    tick();
    check("t2_cycles_held", 32'(cycles_used), 32'd12);
    ack();

    // T3: 33 bytes without host_last, so the load truncates at 32
    run_cycles = 16'd3;
    for (int i = 0; i < 33; i++) begin
      d = 8'(i) ^ 8'h5A;
      if (i < 32) push(5'(i), d);
      send(d, 1'b0);
      if (i == 30) begin
        check("t3_count_31", 32'(load_count), 32'd31);
        check("t3_ready_31", 32'(host_ready), 32'd1);
      end
      if (i == 31) begin
        check("t3_ready_off",  32'(host_ready), 32'd0);
        check("t3_trunc",      32'(load_trunc), 32'd1);
        check("t3_count_32",   32'(load_count), 32'd32);
        check("t3_run",        32'(core_start), 32'd1);
      end
    end
    check("t3_count_sat", 32'(load_count), 32'd32);
    wait_done("t3_done", 10);
    check("t3_cycles_used", 32'(cycles_used), 32'd3);
    check("t3_trunc_held",  32'(load_trunc), 32'd1);
    ack();
    check("t3_trunc_clear", 32'(load_trunc), 32'd0);

    // T4: zero budget skips RUN; the last byte is still written
    run_cycles = 16'd0;
    push(5'd0, 8'h77);
    send(8'h77, 1'b1);
    check("t4_done",        32'(done), 32'd1);
    check("t4_no_start",    32'(core_start), 32'd0);
    check("t4_cycles_used", 32'(cycles_used), 32'd0);
    check("t4_busy",        32'(busy), 32'd0);
    check("t4_last_write",  32'(mem_write), 32'd1);
    tick();
    check("t4_no_start_2",  32'(core_start), 32'd0);
    check("t4_write_off",   32'(mem_write), 32'd0);
    ack();

    // T5: abort ignored in IDLE, honoured in the 5th RUN cycle
    run_cycles = 16'd100;
    abort = 1'b1;
    tick();
    check("t5_abort_idle", 32'(state_dbg), 32'(S_IDLE));
    abort = 1'b0;
    push(5'd0, 8'h11);
    send(8'h11, 1'b1);
    cnt = 0;
    while (core_start && cnt < 1000) begin
      cnt++;
      abort    = (cnt == 5);
      done_ack = (cnt == 2);
      tick();
    end
    abort    = 1'b0;
    done_ack = 1'b0;
    check("t5_run_len",     32'(cnt), 32'd5);
    check("t5_done",        32'(done), 32'd1);
    check("t5_cycles_used", 32'(cycles_used), 32'd5);
    ack();

    // T6: asynchronous reset mid-RUN, then reload and acknowledge
    run_cycles = 16'd50;
    push(5'd0, 8'h31);
    send(8'h31, 1'b1);
    tick();
    tick();
    check("t6_in_run", 32'(core_start), 32'd1);
    core_mem_write = 1'b1;
    core_mem_addr  = 5'd3;
    reset_n        = 1'b0;
    #1;
    check("t6_rst_core_reset", 32'(core_reset), 32'd1);
    check("t6_rst_core_start", 32'(core_start), 32'd0);
    check("t6_rst_mem_write",  32'(mem_write), 32'd0);
    check("t6_rst_busy",       32'(busy), 32'd0);
    check("t6_rst_cycles",     32'(cycles_used), 32'd0);
    core_mem_write = 1'b0;
    core_mem_addr  = 5'd0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("t6_ready_again", 32'(host_ready), 32'd1);
    run_cycles = 16'd2;
    push(5'd0, 8'h42);
    push(5'd1, 8'h43);
    send(8'h42, 1'b0);
    send(8'h43, 1'b1);
    wait_done("t6_done", 10);
    check("t6_cycles_used", 32'(cycles_used), 32'd2);
    check("t6_load_count",  32'(load_count), 32'd2);
    ack();
    check("t6_ack_ready", 32'(host_ready), 32'd1);
    check("t6_ack_state", 32'(state_dbg), 32'(S_IDLE));
    check("t6_ack_done",  32'(done), 32'd0);

    tick();
    check("q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
